// File: rtl/multi_digit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : multi_digit_counter
//  Description : Cascaded per-digit modulo counter (e.g. mm:ss) with run/stop
//                control, clamped preset, expiry and wrap pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_digit_counter #(
  parameter int                      DIGITS       = 4,
  parameter int                      WIDTH        = 4,
  parameter logic [DIGITS*WIDTH-1:0] DIGIT_MAX    = 16'h5959,
  parameter bit                      STOP_AT_ZERO = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [DIGITS*WIDTH-1:0] load_value,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    tick,
  input  logic                    up,
  output logic [DIGITS*WIDTH-1:0] count,
  output logic                    zero_count,
  output logic                    running,
  output logic                    done,
  output logic                    wrap
);

  localparam int c_NB = DIGITS * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_NB-1:0] r_count, w_count_nxt;
  logic            r_done, r_wrap, w_done_nxt, w_wrap_nxt;
  logic [c_NB-1:0] w_load_clamped, w_down_val, w_up_val;
  // w_borrow[i] / w_carry[i]: every digit below i was at 0 / at its max
  logic [DIGITS:0] w_borrow, w_carry;

  assign w_borrow[0] = 1'b1;
  assign w_carry[0]  = 1'b1;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [WIDTH-1:0] w_cur, w_max, w_ld;
    assign w_cur = r_count[gi*WIDTH +: WIDTH];
    assign w_max = DIGIT_MAX[gi*WIDTH +: WIDTH];
    assign w_ld  = load_value[gi*WIDTH +: WIDTH];

    assign w_load_clamped[gi*WIDTH +: WIDTH] = (w_ld > w_max) ? w_max : w_ld;

    assign w_borrow[gi+1] = w_borrow[gi] & (w_cur == '0);
    assign w_down_val[gi*WIDTH +: WIDTH] = !w_borrow[gi]  ? w_cur :
                                           (w_cur == '0)  ? w_max :
                                                            w_cur - 1'b1;

    assign w_carry[gi+1] = w_carry[gi] & (w_cur >= w_max);
    assign w_up_val[gi*WIDTH +: WIDTH] = !w_carry[gi]     ? w_cur :
                                         (w_cur >= w_max) ? '0    :
                                                            w_cur + 1'b1;
  end

  assign count      = r_count;
  assign zero_count = (r_count == '0);
  assign running    = (r_state == S_RUNNING);
  assign done       = r_done;
  assign wrap       = r_wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    if (load) begin
      w_count_nxt = w_load_clamped;
      w_state_nxt = S_IDLE;
    end else if (stop) begin
      if (r_state == S_RUNNING) w_state_nxt = S_IDLE;
    end else if (start && (r_state != S_RUNNING)) begin
      if (!(STOP_AT_ZERO && !up && zero_count)) w_state_nxt = S_RUNNING;
    end else if (tick && (r_state == S_RUNNING)) begin
      if (up) begin
        w_count_nxt = w_up_val;
        w_wrap_nxt  = w_carry[DIGITS];
      end else if (w_borrow[DIGITS]) begin
        // Down tick while already at zero: halt or reload every digit to max
        if (STOP_AT_ZERO) begin
          w_state_nxt = S_EXPIRED;
        end else begin
          w_count_nxt = w_down_val;
          w_wrap_nxt  = 1'b1;
        end
      end else begin
        w_count_nxt = w_down_val;
        if (STOP_AT_ZERO && (w_down_val == '0)) begin
          w_state_nxt = S_EXPIRED;
          w_done_nxt  = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_digit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_digit_counter
//  Description : Scoreboard bench for multi_digit_counter, STOP_AT_ZERO=1 and 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_digit_counter;

  localparam int          DIGITS = 4;
  localparam int          WIDTH  = 4;
  localparam logic [15:0] DMAX   = 16'h5959;
  localparam int          M_IDLE = 0, M_RUN = 1, M_EXP = 2;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        load = 1'b0, start = 1'b0, stop = 1'b0, tick = 1'b0, up = 1'b0;
  logic [15:0] load_value = '0;

  logic [15:0] count_a, count_b;
  logic        zero_a, zero_b, run_a, run_b, done_a, done_b, wrap_a, wrap_b;

  multi_digit_counter #(.DIGITS(DIGITS), .WIDTH(WIDTH), .DIGIT_MAX(DMAX), .STOP_AT_ZERO(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .tick(tick), .up(up),
    .count(count_a), .zero_count(zero_a), .running(run_a), .done(done_a), .wrap(wrap_a));

  multi_digit_counter #(.DIGITS(DIGITS), .WIDTH(WIDTH), .DIGIT_MAX(DMAX), .STOP_AT_ZERO(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .tick(tick), .up(up),
    .count(count_b), .zero_count(zero_b), .running(run_b), .done(done_b), .wrap(wrap_b));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] count;
    logic        done;
    logic        wrap;
    logic        running;
    logic        zero;
  } exp_t;

  exp_t q_a[$], q_b[$];
  exp_t e_a, e_b;
  int   n_checks = 0, n_fail = 0;

  // Reference model: the count is one mixed-radix number in [0, total)
  int   radix[DIGITS];
  int   total;
  int   m_val[2], m_st[2];
  bit   m_done[2], m_wrap[2];

  function automatic int to_lin(input logic [15:0] p);
    int v, mul, d;
    v = 0; mul = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(p[i*WIDTH +: WIDTH]);
      if (d > radix[i] - 1) d = radix[i] - 1;
      v += d * mul;
      mul *= radix[i];
    end
    return v;
  endfunction

  function automatic logic [15:0] to_packed(input int v);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < DIGITS; i++) begin
      p[i*WIDTH +: WIDTH] = 4'(v % radix[i]);
      v = v / radix[i];
    end
    return p;
  endfunction

  function automatic void model_step(input int k, input bit rn, input bit ld, input logic [15:0] lv,
                                     input bit sp, input bit st, input bit tk, input bit u);
    bit saz;
    saz = (k == 0);
    m_done[k] = 1'b0;
    m_wrap[k] = 1'b0;
    if (!rn) begin
      m_val[k] = 0; m_st[k] = M_IDLE;
    end else if (ld) begin
      m_val[k] = to_lin(lv); m_st[k] = M_IDLE;
    end else if (sp) begin
      if (m_st[k] == M_RUN) m_st[k] = M_IDLE;
    end else if (st && m_st[k] != M_RUN) begin
      if (!(saz && !u && m_val[k] == 0)) m_st[k] = M_RUN;
    end else if (tk && m_st[k] == M_RUN) begin
      if (u) begin
        if (m_val[k] == total - 1) m_wrap[k] = 1'b1;
        m_val[k] = (m_val[k] + 1) % total;
      end else if (m_val[k] == 0) begin
        if (saz) m_st[k] = M_EXP;
        else begin m_val[k] = total - 1; m_wrap[k] = 1'b1; end
      end else begin
        m_val[k] = m_val[k] - 1;
        if (saz && m_val[k] == 0) begin m_st[k] = M_EXP; m_done[k] = 1'b1; end
      end
    end
  endfunction

  function automatic exp_t model_out(input int k);
    exp_t e;
    e.count   = to_packed(m_val[k]);
    e.done    = m_done[k];
    e.wrap    = m_wrap[k];
    e.running = (m_st[k] == M_RUN);
    e.zero    = (m_val[k] == 0);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one DUT response per clock edge, compared against the queue head
  always @(posedge clk) begin
    #1;
    if (q_a.size() > 0 && q_b.size() > 0) begin
      e_a = q_a.pop_front();
      e_b = q_b.pop_front();
      chk("a_count",   count_a,        e_a.count);
      chk("a_done",    16'(done_a),    16'(e_a.done));
      chk("a_wrap",    16'(wrap_a),    16'(e_a.wrap));
      chk("a_running", 16'(run_a),     16'(e_a.running));
      chk("a_zero",    16'(zero_a),    16'(e_a.zero));
      chk("b_count",   count_b,        e_b.count);
      chk("b_done",    16'(done_b),    16'(e_b.done));
      chk("b_wrap",    16'(wrap_b),    16'(e_b.wrap));
      chk("b_running", 16'(run_b),     16'(e_b.running));
      chk("b_zero",    16'(zero_b),    16'(e_b.zero));
    end
  end

  task automatic cycle(input bit rn, input bit ld, input logic [15:0] lv,
                       input bit sp, input bit st, input bit tk, input bit u);
    @(negedge clk);
    reset_n = rn; load = ld; load_value = lv; stop = sp; start = st; tick = tk; up = u;
    for (int k = 0; k < 2; k++) model_step(k, rn, ld, lv, sp, st, tk, u);
    q_a.push_back(model_out(0));
    q_b.push_back(model_out(1));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_a_count"}, count_a, 16'h0000);
    chk({tag, "_a_run"},   16'(run_a),  16'd0);
    chk({tag, "_a_pulse"}, 16'(done_a | wrap_a), 16'd0);
    chk({tag, "_a_zero"},  16'(zero_a), 16'd1);
    chk({tag, "_b_count"}, count_b, 16'h0000);
    chk({tag, "_b_run"},   16'(run_b),  16'd0);
    chk({tag, "_b_pulse"}, 16'(done_b | wrap_b), 16'd0);
    chk({tag, "_b_zero"},  16'(zero_b), 16'd1);
  endtask

  // Asserts reset between edges, after the monitor has consumed the last edge
  task automatic async_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    for (int k = 0; k < 2; k++) begin m_val[k] = 0; m_st[k] = M_IDLE; m_done[k] = 0; m_wrap[k] = 0; end
  endtask

  initial begin
    logic [15:0] dmax_v;
    int          r;
    dmax_v = DMAX;
    total  = 1;
    for (int i = 0; i < DIGITS; i++) begin
      radix[i] = int'(dmax_v[i*WIDTH +: WIDTH]) + 1;
      total *= radix[i];
    end
    for (int k = 0; k < 2; k++) begin m_val[k] = 0; m_st[k] = M_IDLE; m_done[k] = 0; m_wrap[k] = 0; end

    #2;
    check_reset_state("reset");
    cycle(0, 1, 16'h1234, 0, 1, 1, 1);      // inputs ignored while in reset
    cycle(1, 0, 16'h0000, 0, 0, 0, 0);

    // 01:00 -> 00:59
    cycle(1, 1, 16'h0100, 0, 0, 0, 0);
    cycle(1, 0, 16'h0000, 0, 1, 0, 0);
    cycle(1, 0, 16'h0000, 0, 0, 1, 0);
    cycle(1, 0, 16'h0000, 0, 0, 0, 0);

    // Expiry, then ticks ignored
    cycle(1, 1, 16'h0001, 0, 0, 0, 0);
    cycle(1, 0, 16'h0000, 0, 1, 0, 0);
    cycle(1, 0, 16'h0000, 0, 0, 1, 0);
    cycle(1, 0, 16'h0000, 0, 0, 1, 0);
    cycle(1, 0, 16'h0000, 0, 0, 1, 0);

    // Start at zero counting down
    cycle(1, 1, 16'h0000, 0, 0, 0, 0);
    cycle(1, 0, 16'h0000, 0, 1, 0, 0);
    cycle(1, 0, 16'h0000, 0, 0, 1, 0);

    // Up wrap from 59:59
    cycle(1, 1, 16'h5959, 0, 0, 0, 0);
    cycle(1, 0, 16'h0000, 0, 1, 0, 1);
    cycle(1, 0, 16'h0000, 0, 0, 1, 1);
    cycle(1, 0, 16'h0000, 0, 0, 0, 1);

    // Clamping, then start+stop+tick, then load+tick
    cycle(1, 1, 16'h7A9F, 0, 0, 0, 0);
    cycle(1, 0, 16'h0000, 0, 1, 0, 0);
    cycle(1, 0, 16'h0000, 1, 1, 1, 0);
    cycle(1, 1, 16'h1234, 0, 0, 1, 0);
    cycle(1, 0, 16'h0000, 0, 0, 0, 0);

    // 3 -> 2,1,0 then wrap (STOP_AT_ZERO=0) / expired (STOP_AT_ZERO=1)
    cycle(1, 1, 16'h0003, 0, 0, 0, 0);
    cycle(1, 0, 16'h0000, 0, 1, 0, 0);
    for (int t = 0; t < 4; t++) cycle(1, 0, 16'h0000, 0, 0, 1, 0);
    cycle(1, 0, 16'h0000, 0, 0, 1, 0);
    async_reset();
    cycle(0, 0, 16'h0000, 0, 1, 1, 0);
    cycle(1, 0, 16'h0000, 0, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [15:0] lv;
      if (n == 700) async_reset();
      r  = $urandom_range(0, 99);
      lv = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      cycle((n < 700 || n >= 702), (r < 4), lv, ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
    end

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 5 && (q_a.size() > 0 || q_b.size() > 0); w++) begin
      @(posedge clk);
      #2;
    end
    chk("queue_a_drained", 16'(q_a.size()), 16'd0);
    chk("queue_b_drained", 16'(q_b.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_digit_counter.md
MULTI_DIGIT_COUNTER -- requirements
Module: multi_digit_counter

Interface
REQ-001 SHALL provide these parameters:
- DIGITS, default 4: number of cascaded digits.
- WIDTH, default 4: bits per digit.
- DIGIT_MAX, default 16'h5959: packed per-digit maximum, DIGITS*WIDTH bits, digit 0 in the LSBs (default is mm:ss).
- STOP_AT_ZERO, default 1: in down mode, 1 = halt at all-zero, 0 = wrap.
REQ-002 SHALL provide these ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- load  in  1  synchronous preset strobe
- load_value  in  DIGITS*WIDTH  preset value, packed digits
- start  in  1  run request
- stop  in  1  pause request
- tick  in  1  single-cycle count-step qualifier
- up  in  1  direction: 1 = up, 0 = down, sampled on each tick
- count  out  DIGITS*WIDTH  registered digit values
- zero_count  out  1  combinational, count == 0
- running  out  1  state == RUNNING
- done  out  1  one-cycle pulse on expiry
- wrap  out  1  one-cycle pulse on full-range wrap

Function
REQ-003 The FSM SHALL have three states: IDLE, RUNNING and EXPIRED.
REQ-004 Input priority each cycle SHALL be: load > stop > start > tick.
REQ-005 load SHALL act in any state:
- count <= load_value, with each digit above its DIGIT_MAX field clamped to that maximum;
- state <= IDLE;
- the tick in the same cycle is ignored.
REQ-006 start SHALL move the FSM from IDLE or EXPIRED to RUNNING, except when STOP_AT_ZERO=1, up=0 and count==0; in that case start is ignored.
REQ-007 stop SHALL move RUNNING to IDLE with count held. When stop and start are both asserted, stop wins.
REQ-008 count SHALL change only when state==RUNNING and tick==1, by exactly one step per tick.
REQ-009 Down step:
- digit 0 decrements;
- digit i>0 decrements only if all lower digits were 0 before the tick;
- a digit at 0 that is borrowed through reloads to its DIGIT_MAX;
- the whole ripple resolves in the same cycle.
REQ-010 Up step:
- digit 0 increments;
- digit i>0 increments only if all lower digits were at their max;
- a digit at its max that is carried through goes to 0;
- the whole ripple resolves in the same cycle.
REQ-011 Down expiry with STOP_AT_ZERO=1: on the tick whose result is all-zero,
- state SHALL become EXPIRED;
- done SHALL be high for exactly the next cycle, which is the first cycle in which count reads zero.
REQ-012 In EXPIRED, count SHALL hold and ticks SHALL be ignored.
REQ-013 Down with STOP_AT_ZERO=0: a tick at all-zero SHALL load every digit with its DIGIT_MAX and pulse wrap for one cycle; state stays RUNNING and done is not asserted.
REQ-014 Up: a tick with every digit at its max SHALL give all-zero and pulse wrap for one cycle; state stays RUNNING, done is not asserted and STOP_AT_ZERO has no effect.
REQ-015 up MAY change between ticks; each tick SHALL use the up value in its own cycle.
REQ-016 Digit values above DIGIT_MAX SHALL never appear on count.
REQ-017 done and wrap SHALL be registered and SHALL never be asserted in the same cycle.
REQ-018 Non-tick cycles SHALL not modify count, done or wrap (done and wrap return to 0).
REQ-019 All arithmetic SHALL be per-digit modulo (DIGIT_MAX field + 1) with no cross-digit binary carry.

Reset
REQ-020 While reset_n==0, asynchronously and independent of clk:
- count = 0;
- state = IDLE;
- done = 0, wrap = 0, running = 0;
- zero_count = 1.
REQ-021 Release of reset_n SHALL take effect at the first rising clk edge after deassertion. No input is sampled while reset_n==0.
REQ-022 Reset asserted mid-RUNNING SHALL abort the run with no done or wrap pulse.

Verification
REQ-023 Bench SHALL cover at least these directed scenarios (default parameters unless stated):
- Load 16'h0100, start, up=0, 1 tick -> count=16'h0059 (borrow ripples; 01:00 -> 00:59).
- Load 16'h0001, start, up=0, 1 tick -> count=0, state EXPIRED, done high 1 cycle; further ticks -> count stays 0, done stays 0.
- Load 16'h5959, start, up=1, 1 tick -> count=0, wrap high 1 cycle, running stays 1.
- Load 16'h7A9F -> count=16'h5959 (each digit clamped).
- RUNNING with start+stop+tick in one cycle -> IDLE, count unchanged. Then load+tick in one cycle -> count=load_value, IDLE.
- Load 16'h0003, STOP_AT_ZERO=0, start, up=0, 4 ticks -> 2, 1, 0, 16'h5959 (wrap on the 4th tick, no done). Then reset_n low mid-run -> count=0 immediately, running=0.
